// File: rtl/pipe_cache_pkg.sv
// Shared types and address-split width helpers for the direct-mapped pipe_cache.
package pipe_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Byte bit 0 is dropped, so the tag is whatever remains above index/offset.
    function automatic int tag_w(input int addr_w, input int sets, input int words);
        return addr_w - 1 - $clog2(sets) - $clog2(words);
    endfunction

endpackage

// File: rtl/pipe_cache_data_array.sv
// Reset-free line storage: one combinational read port, one synchronous write port.
module cache_data_array
    import pipe_cache_pkg::*;
#(
    parameter int NUM_SETS        = 8,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int DATA_W          = 16,
    parameter int IDX_W           = idx_w(NUM_SETS),
    parameter int OFF_W           = off_w(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [OFF_W-1:0]  woff,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    input  logic [OFF_W-1:0]  roff,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [NUM_SETS][WORDS_PER_BLOCK];

    always_ff @(posedge clk) begin
        if (we) mem_q[widx][woff] <= wdata;
    end

    assign rdata = mem_q[ridx][roff];

endmodule

// File: rtl/pipe_cache.sv
// Direct-mapped write-through, no-write-allocate cache with block-fill FSM.
// Optional hit/miss counters are built when PIPE_CACHE_STATS_EN is defined.
module pipe_cache
    import pipe_cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int NUM_SETS        = 8,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef PIPE_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int OFF_W = off_w(WORDS_PER_BLOCK);
    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int TAG_W = tag_w(ADDR_W, NUM_SETS, WORDS_PER_BLOCK);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_BLOCK - 1);

    state_e                             state_q, state_d;
    logic [OFF_W-1:0]                   issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]                   rcv_cnt_q, rcv_cnt_d;
    logic [TAG_W-1:0]                   fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]                   fill_idx_q, fill_idx_d;
    logic [NUM_SETS-1:0]                valid_q, valid_d;
    logic [NUM_SETS-1:0][TAG_W-1:0]     tag_q, tag_d;

    logic [OFF_W-1:0]  cpu_off;
    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic              idle, hit, rd_hit, rd_miss, wr_hit, fill_we, last_rcv;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_widx;
    logic [OFF_W-1:0]  arr_woff;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign cpu_off  = cpu_addr[OFF_W:1];
    assign cpu_idx  = cpu_addr[OFF_W+IDX_W:OFF_W+1];
    assign cpu_tag  = cpu_addr[ADDR_W-1:OFF_W+IDX_W+1];

    assign idle     = (state_q == IDLE);
    assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign rd_hit   = idle && cpu_req && !cpu_we && hit;
    assign rd_miss  = idle && cpu_req && !cpu_we && !hit;
    assign wr_hit   = idle && cpu_req && cpu_we && hit;
    assign fill_we  = !idle && mem_rvalid;
    assign last_rcv = (state_q == DRAIN) && mem_rvalid && (rcv_cnt_q == LAST_OFF);

    // Fill returns and write hits never coincide: one needs IDLE, the other excludes it.
    assign arr_we    = wr_hit || fill_we;
    assign arr_widx  = fill_we ? fill_idx_q : cpu_idx;
    assign arr_woff  = fill_we ? rcv_cnt_q  : cpu_off;
    assign arr_wdata = fill_we ? mem_rdata  : cpu_wdata;

    cache_data_array #(
        .NUM_SETS        (NUM_SETS),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .DATA_W          (DATA_W)
    ) u_data (
        .clk   (clk),
        .we    (arr_we),
        .widx  (arr_widx),
        .woff  (arr_woff),
        .wdata (arr_wdata),
        .ridx  (cpu_idx),
        .roff  (cpu_off),
        .rdata (arr_rdata)
    );

    // Outputs are held quiet while reset is asserted, even with a request present.
    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (rst_n) begin
            stall = !idle || rd_miss;
            if (rd_hit) cpu_rdata = arr_rdata;
            if (idle && cpu_req && cpu_we) begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end else if (state_q == FILL) begin
                mem_req  = 1'b1;
                mem_addr = {fill_tag_q, fill_idx_q, issue_cnt_q, 1'b0};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        fill_tag_d  = fill_tag_q;
        fill_idx_d  = fill_idx_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        if (fill_we) rcv_cnt_d = rcv_cnt_q + OFF_W'(1);
        case (state_q)
            IDLE: begin
                if (rd_miss) begin
                    state_d          = FILL;
                    fill_tag_d       = cpu_tag;
                    fill_idx_d       = cpu_idx;
                    issue_cnt_d      = '0;
                    rcv_cnt_d        = '0;
                    valid_d[cpu_idx] = 1'b0;
                end
            end
            FILL: begin
                issue_cnt_d = issue_cnt_q + OFF_W'(1);
                if (issue_cnt_q == LAST_OFF) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_rcv) begin
                    valid_d[fill_idx_q] = 1'b1;
                    tag_d[fill_idx_q]   = fill_tag_q;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            fill_tag_q  <= '0;
            fill_idx_q  <= '0;
            valid_q     <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            fill_tag_q  <= fill_tag_d;
            fill_idx_q  <= fill_idx_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
        end
    end

`ifdef PIPE_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        skip_q, skip_d;

    // The cycle right after a fill replays the held read; it was already counted as a miss.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        skip_d     = last_rcv;
        if (idle && cpu_req && !skip_q) begin
            if (hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            skip_q     <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            skip_q     <= skip_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/pipe_cache.md
# pipe_cache

Parametrised, direct-mapped, write-through cache placed between a pipeline memory stage (instruction fetch or MEM) and a multicycle, pipelined backing memory. It replaces the single-cycle memory port with hit/miss tracking and a block-fill state machine. It drives a `stall` that the pipeline's hazard logic ORs into its existing stall and write-enable gating. The same block is instantiated twice: as the I-cache with writes tied off, and as the D-cache.

## Interface
- `ADDR_W`, 16: CPU and memory byte-address width.
- `DATA_W`, 16: word width.
- `NUM_SETS`, 8: number of lines; power of two, ≥2.
- `WORDS_PER_BLOCK`, 8: words per line; power of two, ≥2.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request this cycle.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: byte address; bit 0 ignored.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: read data, valid when `cpu_req & ~cpu_we & ~stall`.
- `stall` out 1: pipeline must hold its request stable while high.
- `mem_req` out 1: memory request strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: memory byte address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rvalid` in 1: read word returning.
- `mem_rdata` in DATA_W: returned word.
- `hit_count`, `miss_count` out 16: present only under `PIPE_CACHE_STATS_EN`.

## Operation
- Address split (LSB first):
  - bit 0: ignored.
  - offset: log2(WORDS_PER_BLOCK) bits.
  - index: log2(NUM_SETS) bits.
  - tag: the remaining bits.
- Hit = `valid[index] & (tag_array[index] == tag)`.
- FSM has three states: IDLE, FILL, DRAIN.
- IDLE, read hit: `cpu_rdata` is driven combinationally from the data array; `stall` = 0.
- IDLE, read miss: `stall` = 1 combinationally; the miss tag is latched; next state is FILL.
- IDLE, write: write-through, no-write-allocate.
  - `mem_req`=`mem_we`=1 with `cpu_addr`/`cpu_wdata` in the same cycle; `stall` = 0.
  - On a hit, the data array word is updated at the clock edge. On a miss, the array is unchanged.
- FILL:
  - Issue one read per cycle to addresses block_base, block_base+2, ..., using an issue counter from 0 to WORDS_PER_BLOCK−1.
  - After the last issue, go to DRAIN.
- FILL and DRAIN, returns: each `mem_rvalid` writes `mem_rdata` to data[index][rcv_count], then increments rcv_count.
- DRAIN: when rcv_count reaches WORDS_PER_BLOCK−1 and `mem_rvalid` is high:
  - set `valid[index]` and write the tag;
  - go to IDLE. The held request then hits.
- `stall` = 1 throughout FILL and DRAIN. `cpu_req`, `cpu_we` and `cpu_addr` are ignored there.
- Returns in FILL and DRAIN are accepted regardless of whether issue has finished.
- `mem_rvalid` seen while in IDLE is ignored.
- `cpu_req` = 0: no memory traffic, `stall` = 0.
- Reset-state outputs: `stall` 0, all `mem_*` outputs 0, `cpu_rdata` 0.
- Reset mid-fill: all valid bits cleared, state → IDLE, counters → 0. The partial line is never marked valid.

## Timing
- Hit: 0 added cycles.
- Write: 0 added cycles.
- Read-miss penalty with memory latency L (rvalid arrives L cycles after a read's `mem_req`):
  - miss cycle is c0; issues occur c1..cW;
  - the last return is at cW+L; `stall` is high for cycles c0..c(W+L), i.e. W+L+1 cycles;
  - the hit is returned at c(W+L+1).
- The memory accepts one request per cycle and returns reads in order. There is no backpressure.

## Configuration
- `PIPE_CACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE access that hits (read or write);
  - `miss_count` increments on each IDLE access that misses (read or write);
  - both saturate at 16'hFFFF and reset to 0;
  - a read is counted once, at its first (miss) presentation; its post-fill hit is not counted.
- Macro undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Structure
- Package `pipe_cache_pkg` holds:
  - the state enum (IDLE, FILL, DRAIN);
  - the offset/index/tag width derivation functions.
- Sub-module `cache_data_array`: NUM_SETS×WORDS_PER_BLOCK×DATA_W registers with one combinational read port and one write port, reset-free. Fill and write-hit writes are mutually exclusive by state.
- Tags and valid bits live in the parent.

## Test plan (NUM_SETS=8, WORDS_PER_BLOCK=4, L=4)
- Cold read of 0x0010 → `stall` high 9 cycles; reads issued to 0x0010, 0x0012, 0x0014, 0x0016; then `cpu_rdata` = mem[0x0010].
- After that fill, read 0x0016 → hit, `stall` 0, `cpu_rdata` = mem[0x0016], no `mem_req`.
- Write 0xBEEF to 0x0012 (hit) → `mem_we` pulse with that address and data; a following read of 0x0012 returns 0xBEEF with no stall.
- Write to 0x0090 (miss) → memory write only; a following read of 0x0090 misses and fills.
- Conflict: read 0x0010, then read 0x0090 (same index, different tag), then read 0x0010 → three misses; with stats enabled, `miss_count` = 3.
- Assert `rst_n` low during DRAIN → `stall` 0 immediately; late `mem_rvalid` ignored; re-read of 0x0010 misses again.
